rec_play_ctrl: RTL and testbench
================================

# rec_play_ctrl

Parametrised record/playback sequencer for the audio recorder top level. It steps through codec bring-up, idle, record, play and pause. Per audio frame it issues SRAM write or read strobes with an address pointer. It adds what the earlier controller lacked: recorded-length tracking, auto-stop on full or end-of-recording, pause/resume, and fast/slow variable-speed playback.

## Interface
- ADDR_W, 20, SRAM word-address width; capacity 2^ADDR_W samples
- SPEED_W, 3, width of the speed factor; factor range 1..2^SPEED_W-1
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset; one clock, no other clock domains
- init_done  in  1  codec I2C initialisation complete (level)
- play_btn, pause_btn, stop_btn, record_btn  in  1 each  debounced, active-low, level-sampled
- speed_mode  in  1  0 = fast (skip), 1 = slow (repeat)
- speed_val  in  SPEED_W  speed factor; 0 treated as 1
- sample_tick  in  1  one-cycle pulse per audio frame, already synchronous to clk
- rec_data  in  16  ADC sample, stable while sample_tick=1
- mem_rdata  in  16  SRAM read data, combinational, valid within the mem_rd cycle
- mem_addr  out  ADDR_W  SRAM word address
- mem_wr, mem_rd  out  1  one-cycle write/read strobes, never both high
- mem_wdata  out  16  write data
- play_data  out  16  playback sample
- play_valid  out  1  one-cycle pulse with play_data
- state  out  3  INIT=0, IDLE=1, PLAY=2, PAUSE=3, RECORD=4
- rec_len  out  ADDR_W+1  samples recorded
- full  out  1  last recording stopped on capacity

## Operation
- INIT -> IDLE when init_done=1. All buttons ignored in INIT.
- IDLE, priority play > record:
  - play_btn=0 and rec_len!=0 -> PLAY with rd_ptr=0 and rep_cnt=0.
  - play_btn=0 with rec_len=0 is ignored.
  - record_btn=0 -> RECORD with wr_ptr=0, rec_len=0, full=0.
- RECORD:
  - On each tick, write rec_data at wr_ptr, then wr_ptr+1 and rec_len+1.
  - stop_btn=0 -> IDLE, keeping rec_len.
  - When rec_len reaches 2^ADDR_W after a write -> IDLE with full=1. No wrap, no overwrite of address 0.
- PLAY:
  - On each tick, read at rd_ptr.
  - Fast mode: rd_ptr += speed_val.
  - Slow mode: rd_ptr += 1 only when rep_cnt >= speed_val-1, and rep_cnt clears; otherwise rep_cnt+1. Each sample is output speed_val times.
  - Pointer math is done in ADDR_W+1 bits. If the new rd_ptr >= rec_len -> IDLE, rd_ptr=0, after the final sample is output.
  - Priority stop > pause. stop_btn=0 -> IDLE, rd_ptr=0. pause_btn=0 -> PAUSE, holding rd_ptr and rep_cnt.
- PAUSE:
  - No memory access; play_data driven 0.
  - stop_btn=0 -> IDLE, rd_ptr=0. Otherwise play_btn=0 -> PLAY, resuming at the held rd_ptr.
- speed_mode and speed_val are sampled at each tick; a change takes effect on the next tick with no reset of pointers.
- A tick arriving in any state other than RECORD or PLAY produces no strobe.

## Timing
- Reset values:
  - state INIT.
  - mem_addr, mem_wdata, play_data, rec_len all 0.
  - mem_wr, mem_rd, play_valid, full all 0.
  - Internal wr_ptr, rd_ptr, rep_cnt all 0.
- Reset mid-operation discards the recording (rec_len=0). The memory contents are not touched.
- State transitions are registered: a button sampled low at edge E changes state after E.
- A tick sampled in the same cycle a transition out of RECORD or PLAY is taken is dropped: no strobe, no pointer change.
- Tick sampled at edge T:
  - mem_addr and mem_wdata are valid, and mem_wr or mem_rd is high, for exactly cycle T+1.
  - For a read, mem_rdata is captured at the end of T+1, so play_data and play_valid appear in T+2. Latency from tick to play_valid is 2 cycles.
  - mem_addr holds its last value between strobes.
- play_data holds its last value until the next play_valid, except in PAUSE or IDLE where it is 0.
- The auto-stop (end-of-recording or full) transition happens at the same edge as the final strobe. The final write or read still completes.
- Ticks must be at least 3 cycles apart. Behaviour for closer ticks is undefined.

## Test plan
- Reset low mid-RECORD after 5 writes -> all outputs reach reset values immediately; after release with init_done=1 -> state goes 0 then 1, rec_len=0.
- Record 8 ticks then stop_btn=0 -> mem_wr pulses at addresses 0..7 with mem_wdata equal to the rec_data values; rec_len=8; state=1.
- ADDR_W=3, record 10 ticks -> exactly 8 writes (addresses 0..7); state=1, full=1, rec_len=8; no write occurs at tick 9 or 10.
- rec_len=8, fast, speed_val=3 -> reads at addresses 0, 3, 6, then IDLE. Each play_valid arrives 2 cycles after its tick, and play_data equals the memory contents.
- rec_len=4, slow, speed_val=2 -> reads at addresses 0,0,1,1,2,2,3,3, then IDLE. speed_val=0 behaves like 1.
- PLAY, pause_btn=0 after address 2 -> no reads while paused and play_data=0; play_btn=0 -> resumes at address 3. stop_btn and pause_btn low together -> IDLE with rd_ptr=0.

Source files
------------

// File: rtl/rec_play_ctrl_if.sv
// Signal bundle between the record/playback sequencer and the recorder top:
// operator controls, audio tick/sample, SRAM port and playback/status outputs.
interface rec_play_ctrl_if #(
   parameter int ADDR_W  = 20,
   parameter int SPEED_W = 3
);
   logic               init_done;
   logic               play_btn;
   logic               pause_btn;
   logic               stop_btn;
   logic               record_btn;
   logic               speed_mode;
   logic [SPEED_W-1:0] speed_val;
   logic               sample_tick;
   logic [15:0]        rec_data;
   logic [15:0]        mem_rdata;
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_wr;
   logic               mem_rd;
   logic [15:0]        mem_wdata;
   logic [15:0]        play_data;
   logic               play_valid;
   logic [2:0]         state;
   logic [ADDR_W:0]    rec_len;
   logic               full;

   // Sequencer side
   modport master (
      input  init_done, play_btn, pause_btn, stop_btn, record_btn,
      input  speed_mode, speed_val, sample_tick, rec_data, mem_rdata,
      output mem_addr, mem_wr, mem_rd, mem_wdata, play_data, play_valid,
      output state, rec_len, full
   );

   // Environment side (buttons, codec, SRAM)
   modport slave (
      output init_done, play_btn, pause_btn, stop_btn, record_btn,
      output speed_mode, speed_val, sample_tick, rec_data, mem_rdata,
      input  mem_addr, mem_wr, mem_rd, mem_wdata, play_data, play_valid,
      input  state, rec_len, full
   );
endinterface

// File: rtl/rec_play_ctrl.sv
// Record/playback sequencer: codec bring-up wait, idle, record, play, pause.
// One SRAM strobe per accepted audio tick; reads return as play_data two
// cycles after the tick. Tracks recorded length, stops on full or on end of
// recording, and supports fast (skip) / slow (repeat) playback.
module rec_play_ctrl #(
   parameter int ADDR_W  = 20,
   parameter int SPEED_W = 3
) (
   input  logic            clk,
   input  logic            reset,
   rec_play_ctrl_if.master bus
);
   localparam int AW1 = ADDR_W + 1;
   localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_IDLE   = 3'd1,
      S_PLAY   = 3'd2,
      S_PAUSE  = 3'd3,
      S_RECORD = 3'd4
   } state_t;

   // A speed factor of zero behaves as one
   function automatic logic [SPEED_W-1:0] f_speed_factor(input logic [SPEED_W-1:0] val);
      return (val == '0) ? SPEED_W'(1) : val;
   endfunction

   state_t             r_state;
   state_t             w_state_nxt;
   logic [ADDR_W-1:0]  r_wr_ptr;
   logic [ADDR_W-1:0]  w_wr_ptr_nxt;
   logic [ADDR_W:0]    r_rd_ptr;
   logic [ADDR_W:0]    w_rd_ptr_nxt;
   logic [ADDR_W:0]    w_rd_ptr_adv;
   logic [SPEED_W-1:0] r_rep_cnt;
   logic [SPEED_W-1:0] w_rep_cnt_nxt;
   logic [SPEED_W-1:0] w_speed;
   logic [ADDR_W:0]    r_rec_len;
   logic [ADDR_W:0]    w_rec_len_nxt;
   logic               r_full;
   logic               w_full_nxt;
   logic               w_wr_en;
   logic               w_rd_en;

   logic [ADDR_W-1:0]  r_mem_addr_p1;
   logic [15:0]        r_mem_wdata_p1;
   logic               r_wr_vld_p1;
   logic               r_rd_vld_p1;
   logic [15:0]        r_play_data_p2;
   logic               r_play_vld_p2;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_INIT;
      else        r_state <= w_state_nxt;
   end

   // Next state, pointer updates and strobe requests; a tick seen on the
   // same edge as a button-driven exit is dropped
   always_comb begin
      w_state_nxt   = r_state;
      w_wr_ptr_nxt  = r_wr_ptr;
      w_rd_ptr_nxt  = r_rd_ptr;
      w_rd_ptr_adv  = r_rd_ptr;
      w_rep_cnt_nxt = r_rep_cnt;
      w_rec_len_nxt = r_rec_len;
      w_full_nxt    = r_full;
      w_wr_en       = 1'b0;
      w_rd_en       = 1'b0;
      w_speed       = f_speed_factor(bus.speed_val);
      case (r_state)
         S_INIT: begin
            if (bus.init_done) w_state_nxt = S_IDLE;
         end
         S_IDLE: begin
            if (!bus.play_btn && (r_rec_len != '0)) begin
               w_state_nxt   = S_PLAY;
               w_rd_ptr_nxt  = '0;
               w_rep_cnt_nxt = '0;
            end else if (!bus.record_btn) begin
               w_state_nxt   = S_RECORD;
               w_wr_ptr_nxt  = '0;
               w_rec_len_nxt = '0;
               w_full_nxt    = 1'b0;
            end
         end
         S_RECORD: begin
            if (!bus.stop_btn) begin
               w_state_nxt = S_IDLE;
            end else if (bus.sample_tick) begin
               w_wr_en       = 1'b1;
               w_wr_ptr_nxt  = r_wr_ptr + 1'b1;
               w_rec_len_nxt = r_rec_len + 1'b1;
               // Memory full: stop here rather than wrap onto address 0
               if (w_rec_len_nxt == CAPACITY) begin
                  w_state_nxt = S_IDLE;
                  w_full_nxt  = 1'b1;
               end
            end
         end
         S_PLAY: begin
            if (!bus.stop_btn) begin
               w_state_nxt   = S_IDLE;
               w_rd_ptr_nxt  = '0;
               w_rep_cnt_nxt = '0;
            end else if (!bus.pause_btn) begin
               w_state_nxt = S_PAUSE;
            end else if (bus.sample_tick) begin
               w_rd_en = 1'b1;
               if (!bus.speed_mode) begin
                  w_rd_ptr_adv = r_rd_ptr + AW1'(w_speed);
               end else if (r_rep_cnt >= (w_speed - 1'b1)) begin
                  w_rd_ptr_adv  = r_rd_ptr + 1'b1;
                  w_rep_cnt_nxt = '0;
               end else begin
                  w_rep_cnt_nxt = r_rep_cnt + 1'b1;
               end
               // Past the recorded length: this read is the last one
               if (w_rd_ptr_adv >= r_rec_len) begin
                  w_state_nxt   = S_IDLE;
                  w_rd_ptr_nxt  = '0;
                  w_rep_cnt_nxt = '0;
               end else begin
                  w_rd_ptr_nxt = w_rd_ptr_adv;
               end
            end
         end
         S_PAUSE: begin
            if (!bus.stop_btn) begin
               w_state_nxt   = S_IDLE;
               w_rd_ptr_nxt  = '0;
               w_rep_cnt_nxt = '0;
            end else if (!bus.play_btn) begin
               w_state_nxt = S_PLAY;
            end
         end
         default: begin
            w_state_nxt = S_INIT;
         end
      endcase
   end

   // Pointers, recorded length and capacity flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_rep_cnt <= '0;
         r_rec_len <= '0;
         r_full    <= 1'b0;
      end else begin
         r_wr_ptr  <= w_wr_ptr_nxt;
         r_rd_ptr  <= w_rd_ptr_nxt;
         r_rep_cnt <= w_rep_cnt_nxt;
         r_rec_len <= w_rec_len_nxt;
         r_full    <= w_full_nxt;
      end
   end

   // Stage p1: SRAM strobe cycle; address and write data hold between strobes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_vld_p1    <= 1'b0;
         r_rd_vld_p1    <= 1'b0;
         r_mem_addr_p1  <= '0;
         r_mem_wdata_p1 <= '0;
      end else begin
         r_wr_vld_p1 <= w_wr_en;
         r_rd_vld_p1 <= w_rd_en;
         if (w_wr_en) begin
            r_mem_addr_p1  <= r_wr_ptr;
            r_mem_wdata_p1 <= bus.rec_data;
         end else if (w_rd_en) begin
            r_mem_addr_p1  <= r_rd_ptr[ADDR_W-1:0];
         end
      end
   end

   // Stage p2: capture read data; an in-flight read always completes, and
   // otherwise the output is cleared whenever playback is not running
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_play_vld_p2  <= 1'b0;
         r_play_data_p2 <= '0;
      end else begin
         r_play_vld_p2 <= r_rd_vld_p1;
         if (r_rd_vld_p1) begin
            r_play_data_p2 <= bus.mem_rdata;
         end else if (w_state_nxt != S_PLAY) begin
            r_play_data_p2 <= '0;
         end
      end
   end

   assign bus.mem_addr   = r_mem_addr_p1;
   assign bus.mem_wr     = r_wr_vld_p1;
   assign bus.mem_rd     = r_rd_vld_p1;
   assign bus.mem_wdata  = r_mem_wdata_p1;
   assign bus.play_data  = r_play_data_p2;
   assign bus.play_valid = r_play_vld_p2;
   assign bus.state      = r_state;
   assign bus.rec_len    = r_rec_len;
   assign bus.full       = r_full;
endmodule

// File: tb/tb_rec_play_ctrl.sv
// Bench for rec_play_ctrl: directed scenarios plus random button/tick traffic,
// checked every cycle against a behavioural model of the recorder.
module tb_rec_play_ctrl;
   localparam int AW  = 4;
   localparam int SW  = 3;
   localparam int CAP = 1 << AW;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   rec_play_ctrl_if #(.ADDR_W(AW), .SPEED_W(SW)) bus ();
   rec_play_ctrl #(.ADDR_W(AW), .SPEED_W(SW)) dut (.clk(clk), .reset(reset), .bus(bus));

   // SRAM: synchronous write, combinational read
   logic [15:0] sram [CAP];
   assign bus.mem_rdata = sram[bus.mem_addr];
   always @(posedge clk) if (bus.mem_wr) sram[bus.mem_addr] <= bus.mem_wdata;

   int n_vec = 0;
   int n_err = 0;
   int wr_log[$];
   int rd_log[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic compare_q(input string nm, input int got[$], input int exp[$]);
      check({nm, "_count"}, got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         check(nm, got[i], exp[i]);
   endtask

   // ---------------- behavioural model ----------------
   // mode codes are the externally visible state codes
   int          m_mode = 0;
   int          m_len  = 0;
   int          m_pos  = 0;
   int          m_rep  = 0;
   bit          m_full = 1'b0;
   logic [15:0] m_mem [CAP];
   // expected outputs for the cycle following the latest edge
   bit          e_wr = 1'b0, e_rd = 1'b0, e_pv = 1'b0;
   int          e_addr = 0;
   logic [15:0] e_wdata = '0, e_pdata = '0;

   task automatic model_step();
      bit nw, nr, npv;
      int na, step, np;
      logic [15:0] nwd, npd;
      nw  = 1'b0;
      nr  = 1'b0;
      na  = e_addr;
      nwd = e_wdata;
      npv = e_rd;
      npd = e_rd ? m_mem[e_addr] : e_pdata;
      step = (bus.speed_val == 0) ? 1 : int'(bus.speed_val);
      case (m_mode)
         0: if (bus.init_done) m_mode = 1;
         1: begin
            if (!bus.play_btn && m_len != 0) begin
               m_mode = 2; m_pos = 0; m_rep = 0;
            end else if (!bus.record_btn) begin
               m_mode = 4; m_len = 0; m_full = 1'b0;
            end
         end
         4: begin
            if (!bus.stop_btn) m_mode = 1;
            else if (bus.sample_tick) begin
               nw = 1'b1; na = m_len; nwd = bus.rec_data;
               m_mem[m_len] = bus.rec_data;
               m_len++;
               if (m_len == CAP) begin m_mode = 1; m_full = 1'b1; end
            end
         end
         2: begin
            if (!bus.stop_btn) begin
               m_mode = 1; m_pos = 0; m_rep = 0;
            end else if (!bus.pause_btn) begin
               m_mode = 3;
            end else if (bus.sample_tick) begin
               nr = 1'b1; na = m_pos;
               if (!bus.speed_mode) np = m_pos + step;
               else if (m_rep >= step - 1) begin np = m_pos + 1; m_rep = 0; end
               else begin np = m_pos; m_rep++; end
               if (np >= m_len) begin m_mode = 1; m_pos = 0; m_rep = 0; end
               else m_pos = np;
            end
         end
         3: begin
            if (!bus.stop_btn) begin
               m_mode = 1; m_pos = 0; m_rep = 0;
            end else if (!bus.play_btn) begin
               m_mode = 2;
            end
         end
         default: m_mode = 0;
      endcase
      if (!npv && m_mode != 2) npd = '0;
      e_wr = nw; e_rd = nr; e_addr = na; e_wdata = nwd; e_pv = npv; e_pdata = npd;
   endtask

   task automatic model_reset();
      m_mode = 0; m_len = 0; m_pos = 0; m_rep = 0; m_full = 1'b0;
      e_wr = 1'b0; e_rd = 1'b0; e_pv = 1'b0; e_addr = 0; e_wdata = '0; e_pdata = '0;
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) model_reset();
         else        model_step();
      end
   end

   // Every-cycle comparison against the model, plus strobe logging
   initial begin
      forever begin
         @(negedge clk);
         check("state",      bus.state,      m_mode);
         check("rec_len",    bus.rec_len,    m_len);
         check("full",       bus.full,       m_full);
         check("mem_wr",     bus.mem_wr,     e_wr);
         check("mem_rd",     bus.mem_rd,     e_rd);
         check("mem_addr",   bus.mem_addr,   e_addr);
         check("mem_wdata",  bus.mem_wdata,  e_wdata);
         check("play_valid", bus.play_valid, e_pv);
         check("play_data",  bus.play_data,  e_pdata);
         check("wr_rd_excl", bus.mem_wr & bus.mem_rd, 1'b0);
         if (bus.mem_wr) wr_log.push_back(int'(bus.mem_addr));
         if (bus.mem_rd) rd_log.push_back(int'(bus.mem_addr));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // low bits: {play, pause, stop, record}, held low for one cycle
   task automatic buttons(input logic [3:0] low);
      bus.play_btn   = ~low[3];
      bus.pause_btn  = ~low[2];
      bus.stop_btn   = ~low[1];
      bus.record_btn = ~low[0];
      step(1);
      bus.play_btn = 1'b1; bus.pause_btn = 1'b1; bus.stop_btn = 1'b1; bus.record_btn = 1'b1;
   endtask

   task automatic do_tick();
      bus.rec_data    = 16'($urandom);
      bus.sample_tick = 1'b1;
      step(1);
      bus.sample_tick = 1'b0;
      step(2);
   endtask

   task automatic record_n(input int n);
      buttons(4'b0001);
      repeat (n) do_tick();
      buttons(4'b0010);
   endtask

   task automatic play_until_idle(input int limit);
      int n;
      n = 0;
      while (bus.state == 3'd2 && n < limit) begin do_tick(); n++; end
      check("play_timeout", n < limit, 1'b1);
      step(3);
   endtask

   initial begin
      int exp_q[$];
      int last_tick;
      bus.init_done = 1'b0; bus.play_btn = 1'b1; bus.pause_btn = 1'b1;
      bus.stop_btn = 1'b1; bus.record_btn = 1'b1; bus.speed_mode = 1'b0;
      bus.speed_val = 3'd1; bus.sample_tick = 1'b0; bus.rec_data = '0;
      #1 reset = 1'b0;
      step(3);
      reset = 1'b1;

      // INIT ignores buttons until the codec is up
      bus.record_btn = 1'b0;
      step(3);
      bus.record_btn = 1'b1;
      check("init_hold", bus.state, 3'd0);
      bus.init_done = 1'b1;
      step(1);
      check("init_to_idle", bus.state, 3'd1);

      // Play with nothing recorded is ignored
      buttons(4'b1000);
      check("play_empty", bus.state, 3'd1);

      // Record 8 samples then stop
      wr_log.delete();
      record_n(8);
      exp_q = '{0, 1, 2, 3, 4, 5, 6, 7};
      compare_q("rec8_addr", wr_log, exp_q);
      check("rec8_len", bus.rec_len, 5'd8);
      check("rec8_state", bus.state, 3'd1);

      // Fast x3 over 8 samples
      bus.speed_mode = 1'b0; bus.speed_val = 3'd3;
      rd_log.delete();
      buttons(4'b1000);
      play_until_idle(40);
      exp_q = '{0, 3, 6};
      compare_q("fast3", rd_log, exp_q);
      check("fast3_idle", bus.state, 3'd1);

      // Slow x2 and slow with factor 0 over 4 samples
      record_n(4);
      bus.speed_mode = 1'b1; bus.speed_val = 3'd2;
      rd_log.delete();
      buttons(4'b1000);
      play_until_idle(40);
      exp_q = '{0, 0, 1, 1, 2, 2, 3, 3};
      compare_q("slow2", rd_log, exp_q);
      bus.speed_val = 3'd0;
      rd_log.delete();
      buttons(4'b1000);
      play_until_idle(40);
      exp_q = '{0, 1, 2, 3};
      compare_q("slow0", rd_log, exp_q);

      // Capacity: 18 ticks give exactly CAP writes
      wr_log.delete();
      record_n(CAP + 2);
      exp_q.delete();
      for (int i = 0; i < CAP; i++) exp_q.push_back(i);
      compare_q("full_addr", wr_log, exp_q);
      check("full_flag", bus.full, 1'b1);
      check("full_len", bus.rec_len, 5'd16);

      // Pause / resume / stop-over-pause
      record_n(8);
      check("full_cleared", bus.full, 1'b0);
      bus.speed_mode = 1'b0; bus.speed_val = 3'd1;
      rd_log.delete();
      buttons(4'b1000);
      repeat (3) do_tick();
      exp_q = '{0, 1, 2};
      compare_q("pre_pause", rd_log, exp_q);
      buttons(4'b0100);
      check("paused", bus.state, 3'd3);
      check("pause_data", bus.play_data, 16'd0);
      rd_log.delete();
      repeat (2) do_tick();
      check("pause_noread", rd_log.size(), 0);
      buttons(4'b1000);
      do_tick();
      exp_q = '{3};
      compare_q("resume", rd_log, exp_q);
      buttons(4'b0110);
      check("stop_pause", bus.state, 3'd1);
      rd_log.delete();
      buttons(4'b1000);
      do_tick();
      exp_q = '{0};
      compare_q("restart", rd_log, exp_q);
      buttons(4'b0010);

      // Reset in the middle of a recording
      buttons(4'b0001);
      repeat (5) do_tick();
      reset = 1'b0;
      #1;
      check("rst_state", bus.state, 3'd0);
      check("rst_len", bus.rec_len, 5'd0);
      check("rst_addr", bus.mem_addr, 4'd0);
      check("rst_wr", bus.mem_wr, 1'b0);
      step(2);
      reset = 1'b1;
      #1;
      check("rst_rel_init", bus.state, 3'd0);
      step(1);
      check("rst_rel_idle", bus.state, 3'd1);

      // Random traffic
      last_tick = -10;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            bus.speed_mode = 1'($urandom);
            bus.speed_val  = 3'($urandom);
         end
         bus.sample_tick = (i - last_tick >= 3) && ($urandom_range(0, 2) == 0);
         if (bus.sample_tick) last_tick = i;
         bus.rec_data   = 16'($urandom);
         bus.play_btn   = ($urandom_range(0, 5)  != 0);
         bus.record_btn = ($urandom_range(0, 11) != 0);
         bus.stop_btn   = ($urandom_range(0, 39) != 0);
         bus.pause_btn  = ($urandom_range(0, 24) != 0);
         reset          = ($urandom_range(0, 499) != 0);
         step(1);
      end
      bus.sample_tick = 1'b0;
      reset = 1'b1;
      bus.play_btn = 1'b1; bus.pause_btn = 1'b1; bus.stop_btn = 1'b1; bus.record_btn = 1'b1;
      step(4);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
